bf16_dec_conv: RTL and testbench
================================

# bf16_dec_conv

Converts the BF16 result produced by the power/arithmetic unit into a signed 5-digit BCD integer for the seven-segment display driver. It sits directly downstream of the power unit and consumes that unit's `result` and `error` when `done` rises. The integer part is truncated toward zero, then converted serially with double-dabble, one bit per cycle. It uses the same level start/done handshake as the arithmetic units.

## Interface
- `DIGITS`, 5: number of BCD output digits. The design is fixed at 5.
- `BIN_W`, 17: width of the binary magnitude. 99999 fits in 17 bits.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  level request. Sampled in IDLE. Must stay high until `done` is seen.
- `bf16_in`  in  16  BF16 value: {sign, exp[7:0], mant[6:0]}.
- `err_in`  in  1  error flag from the upstream unit.
- `bcd`  out  20  5 BCD digits. Digit 4 (ten-thousands) is in [19:16]; digit 0 (units) is in [3:0].
- `neg`  out  1  sign of the displayed value.
- `ovf`  out  1  magnitude does not fit in 5 digits, or the input is Inf/NaN.
- `err_out`  out  1  upstream error passed through.
- `done`  out  1  conversion complete. Held high until `start` falls.

## Operation
- States:
  - IDLE: `done<=0`. If `start`, latch `bf16_in` and `err_in`, then go to DECODE.
  - DECODE: compute flags and the magnitude, load the shifter, then go to SHIFT. If error or overflow, go straight to DONE.
  - SHIFT: run 17 double-dabble iterations.
  - DONE: `done<=1`. If `!start`, go to IDLE.
- DECODE rules, with e = exp, s = e-127, M = {1,mant} (8 bits):
  - `err_in` latched = 1: `err_out<=1`, `bcd<=0`, `neg<=0`, `ovf<=0`, go to DONE.
  - e=255 (Inf/NaN), or s >= 17: `ovf<=1`, `bcd<=20'h99999`, `neg<=sign`, go to DONE.
  - e=0 (zero/subnormal), or e < 127: magnitude = 0.
  - 0 <= s <= 6: magnitude = M >> (7-s).
  - 7 <= s <= 16: magnitude = M << (s-7), 17-bit result.
  - Magnitude > 99999: `ovf<=1`, `bcd<=20'h99999`, go to DONE.
  - Otherwise: `err_out<=0`, `ovf<=0`. Load the 37-bit shifter as {20'b0, magnitude}, set `cnt<=0`.
- SHIFT, each cycle:
  - For every BCD nibble of the shifter >= 5, add 3.
  - Then shift the whole 37-bit register left by 1.
  - `cnt<=cnt+1`.
  - On the iteration where `cnt==16`: load `bcd` from the post-shift upper 20 bits, go to DONE.
- Sign rule: `neg` = sign AND (magnitude != 0). Negative zero and negative fractions that truncate to 0 display as +0.
- Output stability:
  - `bcd`, `neg`, `ovf` and `err_out` update only on the DECODE→DONE or SHIFT→DONE transition.
  - Between those transitions they hold their previous values, including through IDLE.
- `bf16_in` and `err_in` are latched in IDLE. Later changes do not affect the conversion in flight.

## Timing
- Reset values: `bcd=0`, `neg=0`, `ovf=0`, `err_out=0`, `done=0`. State=IDLE, `cnt=0`, shifter=0.
- Reset takes effect at any time, including mid-SHIFT. The partial conversion is discarded and the outputs return to their reset values.
- Latency, counting the edge that samples `start` in IDLE as edge 1:
  - Normal path: DECODE at edge 2, SHIFT on edges 3–19, `done` high after edge 20.
  - Error/overflow path: `done` high after edge 3.
- `done` stays high while `start` stays high. One cycle after `start` is seen low in DONE, the state is IDLE; `done` clears on the following edge.
- `start` already high on reset release: the conversion begins on the first edge after release.
- Back-to-back conversions: `start` must drop for at least one cycle, observed in DONE, before the next request is accepted.

## Test plan
- `bf16_in=16'h3F80` (1.0), `start` held → after 20 edges `bcd=20'h00001`, `neg=0`, `ovf=0`, `done=1`. Drop `start` → `done=0` within 2 cycles.
- `16'h4700` (32768) → `bcd=20'h32768`. `16'h47C3` (99840) → `bcd=20'h99840`, `ovf=0`.
- `16'hC020` (-2.5) → `bcd=20'h00002`, `neg=1`. `16'hBF00` (-0.5) → `bcd=0`, `neg=0`. `16'h8000` (-0) → `bcd=0`, `neg=0`.
- `16'h47C4` (100352) and `16'h7F80` (Inf) → `ovf=1`, `bcd=20'h99999`, `done` after 3 edges. Inf also gives `neg=0`.
- `err_in=1` with any `bf16_in` → `err_out=1`, `bcd=0`, `done` after 3 edges. A following request with `err_in=0` clears `err_out`.
- Assert `rst` for 1 cycle during SHIFT (about 8 cycles into `16'h4700`) → all outputs 0 immediately. Re-request `16'h3F80` → `bcd=20'h00001`. Also check that changing `bf16_in` mid-conversion does not alter the result.

Source files
------------

// File: rtl/bf16_dec_conv.sv
// BF16 to signed 5-digit BCD converter: truncates toward zero, then runs a serial
// double-dabble conversion one bit per cycle behind a level start/done handshake.
module bf16_dec_conv #(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           bf16_in,
    input  logic                  err_in,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic                  err_out,
    output logic                  done
);
    localparam int SH_W = 4*DIGITS + BIN_W;

    typedef enum logic [1:0] {IDLE, DECODE, SHIFT, DONE} state_t;

    state_t            state;
    logic [15:0]       val;
    logic              err_lat;
    logic              neg_pend;
    logic [4:0]        cnt;
    logic [SH_W-1:0]   shreg;
    logic [SH_W-1:0]   sh_next;
    logic [7:0]        exp_f;
    logic              big;
    logic [BIN_W-1:0]  mag;
    logic              too_big;

    // Integer part of 1.mant * 2^(e-127), valid for e <= 143.
    function automatic logic [BIN_W-1:0] int_mag(input logic [7:0] e, input logic [6:0] m);
        logic [BIN_W-1:0] mm;
        mm = {{(BIN_W-8){1'b0}}, 1'b1, m};
        if (e < 8'd127)
            return '0;
        else if (e <= 8'd133)
            return mm >> (8'd134 - e);
        else
            return mm << (e - 8'd134);
    endfunction

    function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] v);
        logic [SH_W-1:0] t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[BIN_W+4*i +: 4] >= 4'd5)
                t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    assign exp_f   = val[14:7];
    assign big     = (exp_f >= 8'd144);   // covers Inf/NaN as well as s >= 17
    assign mag     = big ? '0 : int_mag(exp_f, val[6:0]);
    assign too_big = big || (mag > 17'd99999);
    assign sh_next = dabble_step(shreg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            val      <= '0;
            err_lat  <= 1'b0;
            neg_pend <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
            bcd      <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            err_out  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        val     <= bf16_in;
                        err_lat <= err_in;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (err_lat) begin
                        err_out <= 1'b1;
                        bcd     <= '0;
                        neg     <= 1'b0;
                        ovf     <= 1'b0;
                        state   <= DONE;
                    end else if (too_big) begin
                        err_out <= 1'b0;
                        ovf     <= 1'b1;
                        bcd     <= 20'h99999;
                        neg     <= val[15];
                        state   <= DONE;
                    end else begin
                        // Sign is held back so outputs change only when the result is ready
                        neg_pend <= val[15] && (mag != '0);
                        shreg    <= {{(4*DIGITS){1'b0}}, mag};
                        cnt      <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= sh_next;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'(BIN_W-1)) begin
                        bcd     <= sh_next[SH_W-1 -: 4*DIGITS];
                        neg     <= neg_pend;
                        ovf     <= 1'b0;
                        err_out <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    if (!start)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_dec_conv.sv
// Scoreboard bench for bf16_dec_conv: driver pushes model results, monitor checks on done.
module tb_bf16_dec_conv;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bf16_in;
    logic        err_in;
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
    logic        err_out;
    logic        done;

    bf16_dec_conv #(.DIGITS(5), .BIN_W(17)) dut (
        .clk(clk), .rst(rst), .start(start), .bf16_in(bf16_in), .err_in(err_in),
        .bcd(bcd), .neg(neg), .ovf(ovf), .err_out(err_out), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_start = 0;
    logic done_q = 1'b0;
    exp_t mon_x;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    // Reference: real-valued BF16 decode, floor, then decimal digit extraction.
    function automatic exp_t model(input logic [15:0] v, input logic e_in);
        exp_t  x;
        real   r;
        longint m;
        longint mag;
        int    ee;
        x.bcd = '0; x.neg = 1'b0; x.ovf = 1'b0; x.err = 1'b0; x.lat = 20;
        if (e_in) begin
            x.err = 1'b1; x.lat = 3;
            return x;
        end
        ee = int'(v[14:7]);
        if (ee == 255) begin
            x.ovf = 1'b1; x.bcd = 20'h99999; x.neg = v[15]; x.lat = 3;
            return x;
        end
        if (ee == 0) r = 0.0;
        else r = (1.0 + real'(int'(v[6:0])) / 128.0) * (2.0 ** real'(ee - 127));
        if (r >= 100000.0) begin
            x.ovf = 1'b1; x.bcd = 20'h99999; x.neg = v[15]; x.lat = 3;
            return x;
        end
        mag = longint'($floor(r));
        m = mag;
        for (int i = 0; i < 5; i++) begin
            x.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        x.neg = v[15] && (mag != 0);
        return x;
    endfunction

    // Monitor: compare on every rising edge of done
    always @(negedge clk) begin
        if (!rst && done && !done_q) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(1'b0));
            end else begin
                mon_x = q.pop_front();
                chk("bcd",     32'(bcd),       32'(mon_x.bcd));
                chk("neg",     32'(neg),       32'(mon_x.neg));
                chk("ovf",     32'(ovf),       32'(mon_x.ovf));
                chk("err_out", 32'(err_out),   32'(mon_x.err));
                chk("latency", 32'(cyc - t_start), 32'(mon_x.lat));
            end
        end
        done_q = done;
    end

    task automatic run(input logic [15:0] v, input logic e, input int hold, input bit midchange);
        exp_t x;
        bit   seen;
        x = model(v, e);
        @(negedge clk);
        bf16_in = v; err_in = e; start = 1'b1; t_start = cyc;
        q.push_back(x);
        if (midchange) begin
            repeat (4) @(negedge clk);
            bf16_in = 16'($urandom); err_in = 1'($urandom);
        end
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            chk("done_timeout", 32'(done), 32'(1'b1));
            q.delete();
        end
        repeat (hold) @(negedge clk);
        if (seen) chk("done_held", 32'(done), 32'(1'b1));
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_clear", 32'(done), 32'(1'b0));
        if (seen) chk("idle_hold_bcd", 32'(bcd), 32'(x.bcd));
    endtask

    initial begin
        logic [15:0] rv;
        logic [7:0]  re;
        rst = 1'b1; start = 1'b0; bf16_in = '0; err_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bcd",  32'(bcd),     32'h0);
        chk("rst_flags", 32'({neg, ovf, err_out, done}), 32'h0);
        rst = 1'b0;

        run(16'h3F80, 1'b0, 2, 1'b0);
        run(16'h4700, 1'b0, 0, 1'b0);
        run(16'h47C3, 1'b0, 1, 1'b0);
        run(16'hC020, 1'b0, 0, 1'b0);
        run(16'hBF00, 1'b0, 0, 1'b0);
        run(16'h8000, 1'b0, 1, 1'b0);
        run(16'h47C4, 1'b0, 0, 1'b0);
        run(16'h7F80, 1'b0, 0, 1'b0);
        run(16'hFF80, 1'b0, 0, 1'b0);
        run(16'h1234, 1'b1, 1, 1'b0);
        run(16'h3F80, 1'b0, 0, 1'b0);
        run(16'h4700, 1'b0, 0, 1'b1);

        // Reset mid-SHIFT after an overflow left non-zero outputs
        run(16'h47C4, 1'b0, 0, 1'b0);
        @(negedge clk);
        bf16_in = 16'h4700; err_in = 1'b0; start = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        #1;
        chk("midrst_bcd",   32'(bcd), 32'h0);
        chk("midrst_flags", 32'({neg, ovf, err_out, done}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run(16'h3F80, 1'b0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            re = 8'($urandom_range(118, 148));
            if ($urandom_range(0, 9) == 0) re = 8'($urandom_range(0, 255));
            rv = {1'($urandom), re, 7'($urandom)};
            run(rv, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
